rv_regfile_sb: RTL and testbench
================================

// Module: rv_regfile_sb
// PURPOSE
//  Parametrised integer register file with integrated scoreboard for the pipelined RISC-V core.
//  Two async read ports, one sync write (writeback) port, optional x0 hardwiring and write->read bypass.
//  Per-register pending bits: set at issue, cleared at writeback; RDYn tells decode whether operand n is valid.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREG      32  number of registers (power of 2, >=2)
//  AW        $clog2(NREG)  register index width
//  ZERO_X0   1   1: reg 0 reads 0, never written, never pending; 0: reg 0 is ordinary
//  BYPASS    1   1: same-cycle WB data forwarded to read ports; 0: read returns stored value
//  INIT_MODE 1   reset contents: 0 -> all zero; 1 -> reg[i] = i (zero-extended)
// PORTS
//  CLK     in   1     clock, all state updates on rising edge
//  RST     in   1     reset, synchronous, active-high
//  RR1     in   AW    read address port 1
//  RR2     in   AW    read address port 2
//  RD1     out  XLEN  read data port 1 (combinational)
//  RD2     out  XLEN  read data port 2 (combinational)
//  RDY1    out  1     operand 1 valid: not pending, or being written back this cycle with BYPASS=1
//  RDY2    out  1     operand 2 valid, same rule
//  WE      in   1     writeback enable (RegWrite)
//  WR      in   AW    writeback register index
//  WD      in   XLEN  writeback data
//  ISS_EN  in   1     instruction issued that will write ISS_RD
//  ISS_RD  in   AW    destination register of issued instruction
//  BUSY    out  NREG  pending bit vector (bit i = reg i awaiting writeback)
// BEHAVIOUR
//  Reset (RST=1 at edge): contents per INIT_MODE (reg 0 = 0 if ZERO_X0); BUSY=0; RST wins over WE/ISS_EN.
//   After reset: RDYn=1 for every address; RDn = init value of RRn.
//  Write: WE=1 at edge -> reg[WR]<=WD; WR=0 with ZERO_X0=1 ignored. Latency 1 cycle.
//  Read: RDn = (ZERO_X0 && RRn==0) ? 0 : (BYPASS && WE && WR==RRn) ? WD : reg[RRn].
//  Scoreboard next state per register i, evaluated at each edge:
//   ISS_EN && ISS_RD==i           -> BUSY[i]<=1 (new producer; wins over simultaneous WB to i)
//   else WE && WR==i              -> BUSY[i]<=0
//   else hold.  ZERO_X0=1: BUSY[0] constant 0.
//  WE to a non-pending register: legal; data written, BUSY unchanged (0).
//  RDYn = ~BUSY[RRn] | (BYPASS && WE && WR==RRn); with BYPASS=0, RDYn = ~BUSY[RRn] only.
//   Same-cycle issue to RRn does not affect RDYn in that cycle (issue takes effect next cycle).
//  Single outstanding write per register assumed by pipeline; re-issue to pending reg keeps BUSY=1,
//   and first WB to it clears it (single bit, no counting).
//  Reset mid-operation: all pending bits dropped, any in-flight WB in the reset cycle discarded.
//  Index width: WR/ISS_RD/RRn >= NREG impossible (AW exact); no wrap logic needed.
//  BUSY output is registered (no combinational path from inputs).
// TESTING
//  1 Reset, INIT_MODE=1: RR1=5,RR2=31 -> RD1=5, RD2=31, RDY1=RDY2=1, BUSY=0.
//  2 WE=1,WR=0,WD=0xDEAD (ZERO_X0=1) then RR1=0 -> RD1=0; BUSY[0] stays 0 after ISS_EN,ISS_RD=0.
//  3 ISS_EN,ISS_RD=7; next cycle RR1=7 -> RDY1=0; then WE,WR=7,WD=0x1234 -> same cycle RD1=0x1234,
//    RDY1=1 (BYPASS=1); next cycle BUSY[7]=0, RD1=0x1234.
//  4 BUSY[3]=1; same edge ISS_EN,ISS_RD=3 and WE,WR=3,WD=0xAA -> reg3=0xAA, BUSY[3]=1 after edge.
//  5 BYPASS=0: BUSY[9]=1, WE,WR=9,WD=0x55, RR2=9 -> RD2=old value, RDY2=0; next cycle RD2=0x55, RDY2=1.
//  6 BUSY[4]=BUSY[12]=1, reg12=0x77; assert RST with WE,WR=12 -> BUSY=0, reg12=12 (INIT_MODE=1).

Source files
------------

// File: rtl/rv_regfile_sb.sv
// Integer register file with two combinational read ports, one writeback port,
// and a per-register pending scoreboard that tells decode when operands are valid.
module rv_regfile_sb #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int AW        = $clog2(NREG),
    parameter int ZERO_X0   = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   RR1,
    input  logic [AW-1:0]   RR2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            RDY1,
    output logic            RDY2,
    input  logic            WE,
    input  logic [AW-1:0]   WR,
    input  logic [XLEN-1:0] WD,
    input  logic            ISS_EN,
    input  logic [AW-1:0]   ISS_RD,
    output logic [NREG-1:0] BUSY
);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_next_s;
    logic            wr_is_x0_s;

    function automatic logic [XLEN-1:0] init_value(input int idx);
        logic [XLEN-1:0] v;
        if (INIT_MODE == 1) begin
            v = XLEN'(idx);
        end else begin
            v = {XLEN{1'b0}};
        end
        return v;
    endfunction

    // Read mux: hardwired x0 first, then same-cycle writeback forwarding, then storage.
    function automatic logic [XLEN-1:0] sel_data(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [AW-1:0]   wr,
        input logic [XLEN-1:0] wd
    );
        logic [XLEN-1:0] v;
        if ((ZERO_X0 != 0) && (addr == {AW{1'b0}})) begin
            v = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && we && (wr == addr)) begin
            v = wd;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    function automatic logic sel_rdy(
        input logic [AW-1:0] addr,
        input logic          busy,
        input logic          we,
        input logic [AW-1:0] wr
    );
        logic v;
        if ((BYPASS != 0) && we && (wr == addr)) begin
            v = 1'b1;
        end else begin
            v = ~busy;
        end
        return v;
    endfunction

    assign wr_is_x0_s = (ZERO_X0 != 0) && (WR == {AW{1'b0}});

    // Scoreboard next state: a new issue outranks a writeback landing on the same register.
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 0; i < NREG; i++) begin
            if ((ZERO_X0 != 0) && (i == 0)) begin
                busy_next_s[i] = 1'b0;
            end else if (ISS_EN && (ISS_RD == AW'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (WE && (WR == AW'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Storage and scoreboard update; reset discards any writeback in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= init_value(i);
            end
            busy_r <= {NREG{1'b0}};
        end else begin
            if (WE && !wr_is_x0_s) begin
                regs_r[WR] <= WD;
            end
            busy_r <= busy_next_s;
        end
    end

    // Operand data and readiness for decode.
    always_comb begin
        RD1  = sel_data(RR1, regs_r[RR1], WE, WR, WD);
        RD2  = sel_data(RR2, regs_r[RR2], WE, WR, WD);
        RDY1 = sel_rdy(RR1, busy_r[RR1], WE, WR);
        RDY2 = sel_rdy(RR2, busy_r[RR2], WE, WR);
    end

    assign BUSY = busy_r;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Scoreboard bench: two register-file configurations driven in lockstep with
// directed then random traffic, checked against an array-based reference model.
module tb_rv_regfile_sb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  RR1 = 5'd0, RR2 = 5'd0, WR = 5'd0, ISS_RD = 5'd0;
    logic [31:0] WD = 32'd0;
    logic        WE = 1'b0, ISS_EN = 1'b0;

    logic [31:0] rd1_a, rd2_a, busy_a, rd1_b, rd2_b, busy_b;
    logic        rdy1_a, rdy2_a, rdy1_b, rdy2_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    // Instance a: x0 hardwired, forwarding, reg[i]=i at reset
    rv_regfile_sb #(.XLEN(32), .NREG(32), .ZERO_X0(1), .BYPASS(1), .INIT_MODE(1)) dut_a (
        .CLK(CLK), .RST(RST), .RR1(RR1), .RR2(RR2), .RD1(rd1_a), .RD2(rd2_a),
        .RDY1(rdy1_a), .RDY2(rdy2_a), .WE(WE), .WR(WR), .WD(WD),
        .ISS_EN(ISS_EN), .ISS_RD(ISS_RD), .BUSY(busy_a)
    );

    // Instance b: ordinary x0, no forwarding, zero at reset
    rv_regfile_sb #(.XLEN(32), .NREG(32), .ZERO_X0(0), .BYPASS(0), .INIT_MODE(0)) dut_b (
        .CLK(CLK), .RST(RST), .RR1(RR1), .RR2(RR2), .RD1(rd1_b), .RD2(rd2_b),
        .RDY1(rdy1_b), .RDY2(rdy2_b), .WE(WE), .WR(WR), .WD(WD),
        .ISS_EN(ISS_EN), .ISS_RD(ISS_RD), .BUSY(busy_b)
    );

    // Reference model: configuration flags and architectural state per instance
    int          zx  [2] = '{1, 0};
    int          byp [2] = '{1, 0};
    int          im  [2] = '{1, 0};
    logic [31:0] mem [2][32];
    logic [31:0] pend[2];

    typedef struct {
        logic [31:0] rd1 [2];
        logic [31:0] rd2 [2];
        logic        rdy1[2];
        logic        rdy2[2];
        logic [31:0] busy[2];
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] model_read(int k, logic [4:0] a);
        if (zx[k] == 1 && a == 5'd0) return 32'd0;
        if (byp[k] == 1 && WE && WR == a) return WD;
        return mem[k][a];
    endfunction

    function automatic logic model_rdy(int k, logic [4:0] a);
        if (byp[k] == 1 && WE && WR == a) return 1'b1;
        return !pend[k][a];
    endfunction

    // Apply the rules of one clock edge using the inputs currently held
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                for (int i = 0; i < 32; i++) mem[k][i] = (im[k] == 1) ? i : 32'd0;
                pend[k] = 32'd0;
            end else begin
                if (WE && !(zx[k] == 1 && WR == 5'd0)) mem[k][WR] = WD;
                if (WE) pend[k][WR] = 1'b0;
                if (ISS_EN) pend[k][ISS_RD] = 1'b1;
                if (zx[k] == 1) pend[k][0] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic iss, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(posedge CLK);
        model_edge();
        #1;
        RST = rst; WE = we; WR = wr; WD = wd; ISS_EN = iss; ISS_RD = ird; RR1 = r1; RR2 = r2;
        for (int k = 0; k < 2; k++) begin
            e.rd1[k]  = model_read(k, r1);
            e.rd2[k]  = model_read(k, r2);
            e.rdy1[k] = model_rdy(k, r1);
            e.rdy2[k] = model_rdy(k, r2);
            e.busy[k] = pend[k];
        end
        exp_q.push_back(e);
    endtask

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("a_rd1",  rd1_a,  e.rd1[0]);
            check("a_rd2",  rd2_a,  e.rd2[0]);
            check("a_rdy1", {31'd0, rdy1_a}, {31'd0, e.rdy1[0]});
            check("a_rdy2", {31'd0, rdy2_a}, {31'd0, e.rdy2[0]});
            check("a_busy", busy_a, e.busy[0]);
            check("b_rd1",  rd1_b,  e.rd1[1]);
            check("b_rd2",  rd2_b,  e.rd2[1]);
            check("b_rdy1", {31'd0, rdy1_b}, {31'd0, e.rdy1[1]});
            check("b_rdy2", {31'd0, rdy2_b}, {31'd0, e.rdy2[1]});
            check("b_busy", busy_b, e.busy[1]);
        end
    end

    initial begin
        logic        we, iss, rst;
        logic [4:0]  wr, ird, r1, r2;
        logic [31:0] wd;
        // Reset, then read reset contents
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd31);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd31);
        // Write to x0, then issue to x0
        step(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0, 5'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd1);
        // Issue to 7, wait, writeback with forwarding, then settled read
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        step(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        // Re-issue coinciding with writeback keeps pending
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd9);
        step(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 5'd3, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd3, 5'd9);
        step(1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd3, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
        // Pending 4 and 12, reset with an in-flight writeback
        step(1'b0, 1'b1, 5'd12, 32'h77, 1'b1, 5'd4, 5'd12, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd4);
        step(1'b1, 1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 5'd12, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd4);
        // Random traffic on a narrow index range so issues, writebacks and reads collide
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            we  = $urandom_range(0, 1);
            iss = ($urandom_range(0, 2) == 0);
            wr  = 5'($urandom_range(0, 15));
            ird = 5'($urandom_range(0, 15));
            wd  = $urandom;
            r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 15));
            r2  = ($urandom_range(0, 3) == 0) ? ird : 5'($urandom_range(0, 31));
            step(rst, we, wr, wd, iss, ird, r1, r2);
        end
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
